doa_angle_lut_ctrl: RTL and testbench

Converts a signed inter-microphone sample lag, produced by the cross-correlation peak search, into an arrival angle. It scales the lag to a cosine index, clamps the index to the table range, and drives the `acos_rom` arccos lookup. It captures the ROM word and emits the angle in 0.1° units, 0..1800, to the beam-map stage. One lag is processed at a time; the block is busy from acceptance until the angle is emitted.

---
 rtl/doa_angle_lut_ctrl.sv | 134 +++++++++++++
 tb/tb_doa_angle_lut_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/doa_angle_lut_ctrl.sv
// Lag-to-angle controller: scales a signed correlation lag to an arccos ROM index,
// clamps it to the table range, reads acos_rom and emits the angle in 0.1 deg units.
// Optional output averaging over the last four ROM angles: define DOA_AVG_EN.
module doa_angle_lut_ctrl #(
  parameter int unsigned LAG_W       = 8,
  parameter int unsigned LAG_GAIN    = 125,
  parameter int unsigned GAIN_SHIFT  = 1,
  parameter int unsigned ADDR_CENTER = 1000,
  parameter int unsigned ADDR_MAX    = 1999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LAG_W-1:0] lag,
  input  logic             lag_valid,
  output logic             lag_ready,
  output logic [10:0]      rom_ad,
  output logic             rom_ce,
  output logic             rom_oce,
  input  logic [15:0]      rom_dout,
  output logic [10:0]      angle,
  output logic             angle_valid,
  output logic             angle_sat
);

  localparam int unsigned PROD_W = LAG_W + 9;
  localparam int unsigned IDX_W  = ((PROD_W > 12) ? PROD_W : 12) + 1;

  typedef enum logic [2:0] {IDLE, MUL, CLAMP, READ, CAP, AVG} state_t;

  state_t                    state;
  logic signed [LAG_W-1:0]   lag_q;
  logic signed [PROD_W-1:0]  prod_q;
  logic                      sat_q;

  logic signed [PROD_W-1:0]  lag_ext;
  logic signed [PROD_W-1:0]  mul_full;
  logic signed [PROD_W-1:0]  prod_next;
  logic signed [IDX_W-1:0]   idx;
  logic                      idx_neg;
  logic                      idx_hi;

  // ROM bits [15:11] carry no angle information.
  logic [4:0] unused_rom_hi;
  assign unused_rom_hi = rom_dout[15:11];

  assign rom_oce   = 1'b1;
  assign rom_ce    = (state == READ);
  assign lag_ready = (state == IDLE) && !reset;

  always_comb begin
    lag_ext   = {{(PROD_W-LAG_W){lag_q[LAG_W-1]}}, lag_q};
    mul_full  = lag_ext * $signed(PROD_W'(LAG_GAIN));
    prod_next = mul_full >>> GAIN_SHIFT;
    idx       = $signed(IDX_W'(ADDR_CENTER))
              + {{(IDX_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
    idx_neg   = idx[IDX_W-1];
    idx_hi    = idx > $signed(IDX_W'(ADDR_MAX));
  end

`ifdef DOA_AVG_EN
  logic [10:0] hist [4];
  logic [12:0] hist_sum;

  always_comb begin
    hist_sum = 13'(hist[0]) + 13'(hist[1]) + 13'(hist[2]) + 13'(hist[3]);
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      lag_q       <= '0;
      prod_q      <= '0;
      sat_q       <= 1'b0;
      rom_ad      <= '0;
      angle       <= '0;
      angle_valid <= 1'b0;
      angle_sat   <= 1'b0;
`ifdef DOA_AVG_EN
      for (int unsigned i = 0; i < 4; i++) hist[i] <= 11'd900;
`endif
    end else begin
      angle_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (lag_valid) begin
            lag_q <= $signed(lag);
            state <= MUL;
          end
        end
        MUL: begin
          prod_q <= prod_next;
          state  <= CLAMP;
        end
        CLAMP: begin
          if (idx_neg) begin
            rom_ad <= '0;
            sat_q  <= 1'b1;
          end else if (idx_hi) begin
            rom_ad <= 11'(ADDR_MAX);
            sat_q  <= 1'b1;
          end else begin
            rom_ad <= idx[10:0];
            sat_q  <= 1'b0;
          end
          state <= READ;
        end
        READ: state <= CAP;
`ifdef DOA_AVG_EN
        CAP: begin
          hist[0]   <= rom_dout[10:0];
          for (int unsigned i = 1; i < 4; i++) hist[i] <= hist[i-1];
          angle_sat <= sat_q;
          state     <= AVG;
        end
        AVG: begin
          angle       <= 11'(hist_sum >> 2);
          angle_valid <= 1'b1;
          state       <= IDLE;
        end
`else
        CAP: begin
          angle       <= rom_dout[10:0];
          angle_sat   <= sat_q;
          angle_valid <= 1'b1;
          state       <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_doa_angle_lut_ctrl.sv
// Scoreboard bench for doa_angle_lut_ctrl (default build): directed lags with
// hand-computed ROM addresses, angles and saturation flags.
module tb_doa_angle_lut_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  lag;
  logic        lag_valid;
  logic        lag_ready;
  logic [10:0] rom_ad;
  logic        rom_ce;
  logic        rom_oce;
  logic [15:0] rom_dout;
  logic [10:0] angle;
  logic        angle_valid;
  logic        angle_sat;

  doa_angle_lut_ctrl #(
    .LAG_W(8), .LAG_GAIN(125), .GAIN_SHIFT(1), .ADDR_CENTER(1000), .ADDR_MAX(1999)
  ) dut (
    .clk(clk), .reset(reset), .lag(lag), .lag_valid(lag_valid), .lag_ready(lag_ready),
    .rom_ad(rom_ad), .rom_ce(rom_ce), .rom_oce(rom_oce), .rom_dout(rom_dout),
    .angle(angle), .angle_valid(angle_valid), .angle_sat(angle_sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Sparse acos_rom image; junk in the upper bits must be ignored.
  function automatic logic [15:0] rom_word(input logic [10:0] a);
    logic [10:0] v;
    case (a)
      11'd0:    v = 11'd1800;
      11'd937:  v = 11'd936;
      11'd1000: v = 11'd899;
      11'd1062: v = 11'd864;
      11'd1937: v = 11'd204;
      11'd1999: v = 11'd0;
      default:  v = 11'd2047;
    endcase
    return {5'b10110, v};
  endfunction

  initial rom_dout = '0;
  always @(posedge clk) if (rom_ce) rom_dout <= rom_word(rom_ad);

  typedef struct {
    int    due;
    int    ad;
    int    ang;
    int    sat;
    string nm;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && angle_valid) begin
      if (sbq.size() == 0) begin
        check("unexpected_angle_valid", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check({e.nm, "_angle"},   int'(angle),     e.ang);
        check({e.nm, "_sat"},     int'(angle_sat), e.sat);
        check({e.nm, "_rom_ad"},  int'(rom_ad),    e.ad);
        check({e.nm, "_latency"}, cyc,             e.due);
      end
    end
  end

  task automatic send(input string nm, input int l, input int ad, input int ang, input int sat);
    int t;
    @(negedge clk);
    lag       = 8'(l);
    lag_valid = 1'b1;
    t = 0;
    while (!lag_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!lag_ready) begin
      check({nm, "_accept_timeout"}, 0, 1);
      lag_valid = 1'b0;
      return;
    end
    sbq.push_back('{cyc + 5, ad, ang, sat, nm});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      lag_valid = 1'b0;
      check({nm, "_ready_busy"}, int'(lag_ready), 0);
      check({nm, "_rom_ce"},     int'(rom_ce),    (i == 2) ? 1 : 0);
    end
    @(negedge clk);
    check({nm, "_ready_back"}, int'(lag_ready), 1);
  endtask

  int v_lag [9] = '{0, 16, -1, 1, 15, -16, 127, -128, -20};
  int v_ad  [9] = '{1000, 1999, 937, 1062, 1937, 0, 1999, 0, 0};
  int v_ang [9] = '{899, 0, 936, 864, 204, 1800, 0, 1800, 1800};
  int v_sat [9] = '{0, 1, 0, 0, 0, 0, 1, 1, 1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts;
    int first;
    int t;
    reset     = 1'b1;
    lag       = '0;
    lag_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_lag_ready",   int'(lag_ready),   1);
    check("reset_angle_valid", int'(angle_valid), 0);
    check("reset_rom_ad",      int'(rom_ad),      0);
    check("reset_angle",       int'(angle),       0);
    check("reset_rom_oce",     int'(rom_oce),     1);

    for (int i = 0; i < 9; i++)
      send($sformatf("lag%0d", v_lag[i]), v_lag[i], v_ad[i], v_ang[i], v_sat[i]);

    // lag_valid held: a new acceptance only every fifth edge.
    @(negedge clk);
    lag       = 8'd0;
    lag_valid = 1'b1;
    accepts   = 0;
    first     = -1;
    for (int i = 0; i < 10; i++) begin
      if (lag_ready) begin
        accepts++;
        sbq.push_back('{cyc + 5, 1000, 899, 0, "held"});
        if (first < 0) first = cyc + 1;
        else check("held_accept_gap", cyc + 1 - first, 5);
      end
      @(negedge clk);
    end
    lag_valid = 1'b0;
    check("held_accept_count", accepts, 2);
    repeat (6) @(negedge clk);

    // Reset while the ROM read is in flight: result must be dropped.
    lag       = 8'hFF;
    lag_valid = 1'b1;
    @(negedge clk);
    lag_valid = 1'b0;
    t = 0;
    while (!rom_ce && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("rst_mid_reached_read", int'(rom_ce), 1);
    check("rst_mid_rom_ad_pre",   int'(rom_ad), 937);
    reset = 1'b1;
    #1;
    check("rst_mid_rom_ad",      int'(rom_ad),      0);
    check("rst_mid_rom_ce",      int'(rom_ce),      0);
    check("rst_mid_angle",       int'(angle),       0);
    check("rst_mid_angle_sat",   int'(angle_sat),   0);
    check("rst_mid_angle_valid", int'(angle_valid), 0);
    check("rst_mid_lag_ready",   int'(lag_ready),   0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_mid_no_valid", int'(angle_valid), 0);
    end
    check("rst_mid_ready_after", int'(lag_ready), 1);

    send("post_reset_lag0", 0, 1000, 899, 0);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
